// File: rtl/bouncing_sprites.sv
// Animates NUM_SPRITES bouncing rectangles over the active VGA area.
// Positions step once per frame. The RGB output is registered, one cycle behind pixelx/pixely.
module bouncing_sprites #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int RECT_W      = 100,
    parameter int RECT_H      = 100,
    parameter int NUM_SPRITES = 2,
    parameter int X_STEP      = 2,
    parameter int Y_STEP      = 1,
    parameter int INIT_X      = 50,
    parameter int INIT_Y      = 50,
    parameter int INIT_DX     = 200,
    parameter int INIT_DY     = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] pixelx,
    input  logic [10:0] pixely,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        frame_tick,
    output logic        bounce
);

    localparam int XMAX = H_ACTIVE - RECT_W;
    localparam int YMAX = V_ACTIVE - RECT_H;

    localparam logic [11:0] XMAX12   = 12'(XMAX);
    localparam logic [11:0] YMAX12   = 12'(YMAX);
    localparam logic [11:0] XSTEP12  = 12'(X_STEP);
    localparam logic [11:0] YSTEP12  = 12'(Y_STEP);
    localparam logic [11:0] RECTW12  = 12'(RECT_W);
    localparam logic [11:0] RECTH12  = 12'(RECT_H);

    if (NUM_SPRITES < 1 || NUM_SPRITES > 7) begin : g_bad_num
        $error("bouncing_sprites: NUM_SPRITES must be in 1..7");
    end

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_init_chk
        if (INIT_X + gi * INIT_DX > XMAX || INIT_Y + gi * INIT_DY > YMAX) begin : g_bad_init
            $error("bouncing_sprites: initial sprite position outside movement limits");
        end
    end

    logic [11:0]            xpos     [NUM_SPRITES];
    logic [11:0]            ypos     [NUM_SPRITES];
    logic [11:0]            xpos_nxt [NUM_SPRITES];
    logic [11:0]            ypos_nxt [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] xdir, ydir, xdir_nxt, ydir_nxt;
    logic                   any_bounce;
    logic                   frame_evt;
    logic [2:0]             colour;
    logic [11:0]            px, py;

    assign px        = {1'b0, pixelx};
    assign py        = {1'b0, pixely};
    assign frame_evt = (pixelx == 11'(H_ACTIVE - 1)) && (pixely == 11'(V_ACTIVE - 1));

    // Reflection clamps to the limit on the step that would reach or cross it, so a sprite never overshoots.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
        any_bounce = 1'b0;
        xdir_nxt   = xdir;
        ydir_nxt   = ydir;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            xpos_nxt[i] = xpos[i];
            ypos_nxt[i] = ypos[i];

            if (xdir[i]) begin
                if (xpos[i] + XSTEP12 >= XMAX12) begin
                    xpos_nxt[i] = XMAX12;
                    xdir_nxt[i] = 1'b0;
                    any_bounce  = 1'b1;
                end else begin
                    xpos_nxt[i] = xpos[i] + XSTEP12;
                end
            end else if (xpos[i] <= XSTEP12) begin
                xpos_nxt[i] = '0;
                xdir_nxt[i] = 1'b1;
                any_bounce  = 1'b1;
            end else begin
                xpos_nxt[i] = xpos[i] - XSTEP12;
            end

            if (ydir[i]) begin
                if (ypos[i] + YSTEP12 >= YMAX12) begin
                    ypos_nxt[i] = YMAX12;
                    ydir_nxt[i] = 1'b0;
                    any_bounce  = 1'b1;
                end else begin
                    ypos_nxt[i] = ypos[i] + YSTEP12;
                end
            end else if (ypos[i] <= YSTEP12) begin
                ypos_nxt[i] = '0;
                ydir_nxt[i] = 1'b1;
                any_bounce  = 1'b1;
            end else begin
                ypos_nxt[i] = ypos[i] - YSTEP12;
            end
        end
    end

    // Scanning from the highest index down lets the lowest covering sprite write last and win.
    always_comb begin
        colour = 3'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (px >= xpos[i] && px < xpos[i] + RECTW12 &&
                py >= ypos[i] && py < ypos[i] + RECTH12) begin
                colour = 3'(i + 1);
            end
        end
    end

    // NOTE: the sprite position arrays are only a few registers and need known start values, so they are reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                xpos[i] <= 12'(INIT_X + i * INIT_DX);
                ypos[i] <= 12'(INIT_Y + i * INIT_DY);
                xdir[i] <= (i % 2 == 0);
                ydir[i] <= 1'b1;
            end
            {r, g, b}  <= 3'b000;
            frame_tick <= 1'b0;
            bounce     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the values from before this edge.
            {r, g, b}  <= colour;
            frame_tick <= frame_evt;
            bounce     <= frame_evt & en & any_bounce;
            if (frame_evt && en) begin
                xpos <= xpos_nxt;
                ypos <= ypos_nxt;
                xdir <= xdir_nxt;
                ydir <= ydir_nxt;
            end
        end
    end

endmodule

// File: doc/bouncing_sprites.md
Name: bouncing_sprites

Overview:
Parametrised successor to the single bouncing-rectangle display generator. Animates NUM_SPRITES independent rectangles, each with its own position, direction and colour, over the active VGA area. Positions update once per frame at the last active pixel; edges clamp and reflect without overshoot. Sits between the VGA timing generator (pixelx/pixely) and the RGB pins, with a registered 1-cycle output.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
RECT_W, 100, sprite width in pixels
RECT_H, 100, sprite height in pixels
NUM_SPRITES, 2, number of sprites (1..7)
X_STEP, 2, horizontal pixels moved per frame
Y_STEP, 1, vertical pixels moved per frame
INIT_X, 50, sprite 0 reset x; sprite i resets at INIT_X + i*INIT_DX
INIT_Y, 50, sprite 0 reset y; sprite i resets at INIT_Y + i*INIT_DY
INIT_DX, 200, reset x spacing between sprites
INIT_DY, 100, reset y spacing between sprites

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
en  in  1  1 = animate at frame tick; 0 = positions frozen, drawing continues
pixelx  in  11  current pixel column
pixely  in  11  current pixel row
r  out  1  red
g  out  1  green
b  out  1  blue
frame_tick  out  1  1-cycle pulse, registered, asserted the cycle after the last active pixel
bounce  out  1  1-cycle pulse coincident with frame_tick when any sprite reversed any direction

Behaviour:
- Reset (rst=0, async): sprite i x = INIT_X+i*INIT_DX, y = INIT_Y+i*INIT_DY; xdir = 1 (right) for even i, 0 (left) for odd i; ydir = 1 (down) for all. r=g=b=0, frame_tick=0, bounce=0. Reset asserted mid-frame takes effect immediately; no partial update survives.
- Limits: XMAX = H_ACTIVE-RECT_W (540), YMAX = V_ACTIVE-RECT_H (380). Elaboration error when an initial position exceeds its limit or NUM_SPRITES is outside 1..7.
- Frame event: pixelx==H_ACTIVE-1 && pixely==V_ACTIVE-1, sampled on clk. On that edge frame_tick<=1 for exactly one cycle. Positions update on the same edge only when en=1.
- X update per sprite (Y identical with YMAX, Y_STEP):
  - xdir=1: if x+X_STEP >= XMAX then x<=XMAX, xdir<=0, bounce event; else x<=x+X_STEP.
  - xdir=0: if x <= X_STEP then x<=0, xdir<=1, bounce event; else x<=x-X_STEP.
  - Sum computed at 12 bits; no wrap-around possible.
- Simultaneous X and Y bounce of one sprite, or several sprites bouncing on the same tick: single bounce pulse.
- en=0 at the frame event: frame_tick still pulses; positions, directions and bounce unchanged (bounce=0).
- Hit test: sprite i covers x_i <= pixelx < x_i+RECT_W and y_i <= pixely < y_i+RECT_H (12-bit compare). Colour of sprite i = 3-bit {r,g,b} = i+1 (sprite0 blue, sprite1 green, sprite2 cyan, ...).
- Priority: the lowest-index covering sprite wins; no sprite covering = black.
- Latency: {r,g,b} registered; reflects the pixelx/pixely presented on the previous clk edge, using the sprite positions held before that edge.
- Pixels outside the active area: normal hit test; the timing block blanks them.

Test Plan:
- Reset, present (50,50) -> next cycle b=1,r=g=0; (150,50) -> black; (250,150) -> g=1; (249,150) -> black.
- One frame event with en=1 -> frame_tick high one cycle, bounce=0; sprite0 now at (52,51), so (51,50) black and (52,51) b=1; sprite1 at (248,151).
- Override X_STEP=3 and run 163 ticks -> sprite0 x=539; tick 164 -> x clamped to 540, bounce=1, xdir=0; tick 165 -> x=537.
- en=0 across 5 frame events -> 5 frame_tick pulses, sprite positions unchanged, bounce never asserted.
- Override INIT_DX=50, INIT_DY=0, present (120,60), covered by both sprites -> b=1 (sprite0 wins); (160,60) -> g=1.
- Assert rst mid-line after 10 ticks -> outputs 0 immediately (asynchronously); after release sprites are back at (50,50) and (250,150).
